m72_sample_port: RTL and testbench
==================================

// Module: m72_sample_port
// PURPOSE
//  Responder on the sound CPU I/O bus (snd_io_addr/data/req plus Z80 RD_n/WR_n).
//  Implements the M72 sample-playback ports: sample ROM address latch, auto-incrementing
//  prefetched sample-ROM read port, and the 8-bit DAC output. Sits beside the sound block;
//  its io_dout is muxed onto the Z80 data-in bus, and sample_out is mixed with the YM2151 output.
// PARAMETERS
//  IO_BASE  8'h80  I/O base; decodes IO_BASE+0 (addr lo), +1 (addr hi), +2 (DAC), +4 (sample read)
//  ADDR_W   18     sample ROM byte-address width
// PORTS
//  CLK_32M        in   1       system clock
//  reset          in   1       synchronous, active-high reset
//  io_addr        in   8       sound CPU I/O address (Z80 A[7:0])
//  io_din         in   8       sound CPU write data
//  io_req         in   1       I/O cycle active (~IORQ_n), level
//  io_rd          in   1       read strobe (~RD_n), level
//  io_wr          in   1       write strobe (~WR_n), level
//  io_dout        out  8       read data for IO_BASE+4
//  io_dout_valid  out  1       io_dout must be selected onto the Z80 bus
//  rom_addr       out  ADDR_W  sample ROM byte address
//  rom_req        out  1       ROM fetch request, level, held until rom_ack
//  rom_ack        in   1       one-cycle pulse; rom_data valid in the same cycle
//  rom_data       in   8       sample ROM byte
//  sample_out     out  16      signed DAC output
//  busy           out  1       prefetch outstanding (debug/verification)
// BEHAVIOUR
//  Reset: sample_addr=0, data_buf=8'h00, rom_req=0, rom_addr=0, sample_out=0, busy=0, FSM=IDLE.
//  Strobes: wr_ev = rising edge of (io_req&io_wr&match); rd_end = falling edge of
//   (io_req&io_rd&io_addr==IO_BASE+4). Z80 strobes span many clocks; one event per access.
//  Writes (on wr_ev, next clock):
//   +0: sample_addr[12:5] <= io_din;  +1: sample_addr[ADDR_W-1:13] <= io_din (upper bits dropped);
//       sample_addr[4:0] <= 0 on either. Both trigger a prefetch from the new address.
//   +2: sample_out <= {io_din ^ 8'h80, 8'h00} (unsigned 8-bit -> signed 16; 8'h80 -> 0).
//   +4 and undecoded offsets: ignored.
//  Read: io_dout = data_buf (registered, stable for whole cycle);
//   io_dout_valid = io_req & io_rd & (io_addr==IO_BASE+4), combinational.
//   On rd_end: sample_addr <= sample_addr+1 (wraps mod 2^ADDR_W), then prefetch.
//  Prefetch FSM:
//   IDLE : trigger -> FETCH; rom_addr<=sample_addr, rom_req<=1, busy<=1.
//   FETCH: rom_req/rom_addr held stable until rom_ack. On rom_ack: rom_req<=0;
//          if restart=0: data_buf<=rom_data, busy<=0 -> IDLE;
//          if restart=1: discard rom_data, clear restart, re-issue from current sample_addr
//          (rom_req low exactly one cycle, stays FETCH).
//   Trigger while FETCH: restart<=1 (request never aborted mid-handshake); multiple
//   triggers collapse into one restart. Trigger and rom_ack same cycle: ack takes
//   the restart path.
//  Latency: trigger -> rom_req high 1 clk; rom_ack -> data_buf updated next clk.
//  Read while busy returns previous data_buf; software spacing covers this (>=4 Z80 clocks).
//  Reset mid-FETCH: rom_req drops next clock; a late rom_ack in IDLE is ignored.
//  Simultaneous wr_ev and rd_end cannot occur (one Z80 strobe at a time); if forced, write wins.
// TESTING
//  Reset: hold reset 4 clks -> sample_out=0, rom_req=0, io_dout=8'h00, busy=0.
//  Write +0=8'h12, +1=8'h03 -> rom_addr=18'h06240 on second fetch, rom_req held until ack.
//  ROM model ack after 6 clks with data 8'h5A -> read +4 gives 8'h5A, valid high only
//   during strobe; at strobe end rom_addr=18'h06241.
//  Write +2=8'h00 -> sample_out=16'h8000; 8'hFF -> 16'h7F00; 8'h80 -> 16'h0000.
//  Set addr to 18'h3FFFF-equivalent (lo=FF, hi=FF) plus 31 reads -> next fetch 18'h00000 (wrap).
//  Address write during outstanding fetch -> first rom_data discarded, second fetch uses new addr.

Source files
------------

// File: rtl/m72_sample_port_if.sv
// Sound-CPU I/O bus and sample-ROM fetch port of the M72 sample player.
// slave = sample port side, master = CPU/ROM side.
interface m72_sample_port_if #(
    parameter int ADDR_W = 18
) ();
    logic [7:0]        io_addr;
    logic [7:0]        io_din;
    logic              io_req;
    logic              io_rd;
    logic              io_wr;
    logic [7:0]        io_dout;
    logic              io_dout_valid;
    logic [ADDR_W-1:0] rom_addr;
    logic              rom_req;
    logic              rom_ack;
    logic [7:0]        rom_data;

    modport slave (
        input  io_addr, io_din, io_req, io_rd, io_wr, rom_ack, rom_data,
        output io_dout, io_dout_valid, rom_addr, rom_req
    );

    modport master (
        output io_addr, io_din, io_req, io_rd, io_wr, rom_ack, rom_data,
        input  io_dout, io_dout_valid, rom_addr, rom_req
    );
endinterface

// File: rtl/m72_sample_port.sv
// M72 sample port: ROM address latch, auto-incrementing prefetched read port, 8-bit DAC.
// Latency: trigger -> rom_req 1 clk, rom_ack -> io_dout 1 clk; ROM side held by rom_req until rom_ack.
module m72_sample_port #(
    parameter logic [7:0] IO_BASE = 8'h80,
    parameter int         ADDR_W  = 18
) (
    input  logic                CLK_32M,
    input  logic                reset,
    m72_sample_port_if.slave    bus,
    output logic [15:0]         sample_out,
    output logic                busy
);
    localparam logic [7:0] A_LO  = IO_BASE;
    localparam logic [7:0] A_HI  = IO_BASE + 8'd1;
    localparam logic [7:0] A_DAC = IO_BASE + 8'd2;
    localparam logic [7:0] A_RD  = IO_BASE + 8'd4;
    localparam logic [ADDR_W-1:0] MID_MASK = ADDR_W'(32'h0000_1FE0);
    localparam logic [ADDR_W-1:0] HI_MASK  = ~ADDR_W'(32'h0000_1FFF);

    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_GAP} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] sample_addr, sample_addr_nxt;
    logic [7:0]        data_buf;
    logic              restart, restart_nxt;
    logic              req_nxt;
    logic              issue, take;
    logic              wr_sel, rd_sel, wr_sel_q, rd_sel_q;
    logic              wr_ev, rd_end, wr_lo, wr_hi, wr_dac, rd_step, trigger;

    assign wr_sel = bus.io_req & bus.io_wr &
                    ((bus.io_addr == A_LO) | (bus.io_addr == A_HI) |
                     (bus.io_addr == A_DAC) | (bus.io_addr == A_RD));
    assign rd_sel = bus.io_req & bus.io_rd & (bus.io_addr == A_RD);

    // Z80 strobes last many clocks: act once per access on the edges.
    assign wr_ev   = wr_sel & ~wr_sel_q;
    assign rd_end  = rd_sel_q & ~rd_sel;
    assign wr_lo   = wr_ev & (bus.io_addr == A_LO);
    assign wr_hi   = wr_ev & (bus.io_addr == A_HI);
    assign wr_dac  = wr_ev & (bus.io_addr == A_DAC);
    assign rd_step = rd_end & ~wr_ev;
    assign trigger = wr_lo | wr_hi | rd_step;

    assign bus.io_dout       = data_buf;
    assign bus.io_dout_valid = rd_sel;

    always_comb begin
        sample_addr_nxt = sample_addr;
        if (wr_lo)
            sample_addr_nxt = (sample_addr & HI_MASK) | (ADDR_W'(bus.io_din) << 5);
        else if (wr_hi)
            sample_addr_nxt = (sample_addr & MID_MASK) | (ADDR_W'(bus.io_din) << 13);
        else if (rd_step)
            sample_addr_nxt = sample_addr + ADDR_W'(1);
    end

    // A trigger during a fetch never aborts the handshake; it marks the
    // result stale and the fetch is reissued after the ack.
    always_comb begin
        state_nxt   = state;
        req_nxt     = bus.rom_req;
        restart_nxt = restart;
        issue       = 1'b0;
        take        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (trigger) begin
                    state_nxt   = ST_FETCH;
                    req_nxt     = 1'b1;
                    restart_nxt = 1'b0;
                    issue       = 1'b1;
                end
            end
            ST_FETCH: begin
                if (bus.rom_ack) begin
                    req_nxt = 1'b0;
                    if (restart | trigger) begin
                        state_nxt   = ST_GAP;
                        restart_nxt = 1'b0;
                    end else begin
                        state_nxt = ST_IDLE;
                        take      = 1'b1;
                    end
                end else if (trigger) begin
                    restart_nxt = 1'b1;
                end
            end
            ST_GAP: begin
                state_nxt = ST_FETCH;
                req_nxt   = 1'b1;
                issue     = 1'b1;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK_32M) begin
        if (reset) begin
            state        <= ST_IDLE;
            restart      <= 1'b0;
            busy         <= 1'b0;
            bus.rom_req  <= 1'b0;
            bus.rom_addr <= '0;
            sample_addr  <= '0;
            data_buf     <= 8'h00;
            sample_out   <= 16'h0000;
            wr_sel_q     <= 1'b0;
            rd_sel_q     <= 1'b0;
        end else begin
            state       <= state_nxt;
            restart     <= restart_nxt;
            busy        <= (state_nxt != ST_IDLE);
            bus.rom_req <= req_nxt;
            sample_addr <= sample_addr_nxt;
            wr_sel_q    <= wr_sel;
            rd_sel_q    <= rd_sel;
            if (issue)
                bus.rom_addr <= sample_addr_nxt;
            if (take)
                data_buf <= bus.rom_data;
            if (wr_dac)
                sample_out <= {bus.io_din ^ 8'h80, 8'h00};
        end
    end
endmodule

// File: tb/tb_m72_sample_port.sv
// Randomized bench for m72_sample_port against a transaction-level model of the sample port.
module tb_m72_sample_port;
    logic        CLK_32M = 1'b0;
    logic        reset;
    logic [15:0] sample_out;
    logic        busy;

    m72_sample_port_if #(.ADDR_W(18)) bus ();

    m72_sample_port #(.IO_BASE(8'h80), .ADDR_W(18)) dut (
        .CLK_32M    (CLK_32M),
        .reset      (reset),
        .bus        (bus.slave),
        .sample_out (sample_out),
        .busy       (busy)
    );

    always #5 CLK_32M = ~CLK_32M;

    int checks = 0;
    int errors = 0;

    // model state
    logic [17:0] m_addr = '0;
    logic [15:0] m_out  = '0;
    logic        fixed_5a = 1'b0;
    int          fixed_dly = 0;
    logic [17:0] fetch_q[$];

    task automatic check(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] rom_byte(input logic [17:0] a);
        if (fixed_5a)
            return 8'h5A;
        return a[7:0] ^ a[15:8] ^ {6'h2B, a[17:16]};
    endfunction

    // ROM responder: acks each request after a delay, checks request stays stable.
    logic [17:0] req_addr;
    int          dly;
    initial begin
        bus.rom_ack  = 1'b0;
        bus.rom_data = 8'h00;
        forever begin
            @(negedge CLK_32M);
            if (bus.rom_req && !reset) begin
                req_addr = bus.rom_addr;
                fetch_q.push_back(req_addr);
                dly = (fixed_dly != 0) ? fixed_dly : int'($urandom_range(1, 8));
                for (int k = 1; k < dly; k++) begin
                    @(negedge CLK_32M);
                    check(bus.rom_req === 1'b1 && bus.rom_addr === req_addr, "rom_hold",
                          32'({bus.rom_req, bus.rom_addr}), 32'({1'b1, req_addr}));
                end
                @(posedge CLK_32M); #1;
                bus.rom_ack  = 1'b1;
                bus.rom_data = rom_byte(req_addr);
                @(posedge CLK_32M); #1;
                bus.rom_ack  = 1'b0;
                bus.rom_data = 8'h00;
                check(bus.rom_req === 1'b0, "rom_drop", 32'(bus.rom_req), 32'(0));
            end
        end
    end

    // Per-cycle compare of the outputs that are always meaningful.
    initial begin
        forever begin
            @(negedge CLK_32M);
            if (!reset) begin
                check(sample_out === m_out, "sample_out", 32'(sample_out), 32'(m_out));
                check(bus.io_dout_valid === (bus.io_req & bus.io_rd & (bus.io_addr == 8'h84)),
                      "io_dout_valid", 32'(bus.io_dout_valid),
                      32'(bus.io_req & bus.io_rd & (bus.io_addr == 8'h84)));
            end
        end
    end

    task automatic io_write(input logic [7:0] a, input logic [7:0] d);
        bus.io_addr = a;
        bus.io_din  = d;
        bus.io_req  = 1'b1;
        bus.io_wr   = 1'b1;
        @(posedge CLK_32M); #1;
        case (a)
            8'h80: m_addr = 18'((int'(m_addr) / 8192) * 8192 + int'(d) * 32);
            8'h81: m_addr = 18'((int'(d) % 32) * 8192 + ((int'(m_addr) / 32) % 256) * 32);
            8'h82: m_out  = 16'((int'(d) - 128) * 256);
            default: ;
        endcase
        repeat (3) @(posedge CLK_32M);
        #1;
        bus.io_req = 1'b0;
        bus.io_wr  = 1'b0;
        @(posedge CLK_32M); #1;
    endtask

    task automatic io_read(input logic [7:0] a, output logic [7:0] v);
        bus.io_addr = a;
        bus.io_req  = 1'b1;
        bus.io_rd   = 1'b1;
        repeat (3) @(posedge CLK_32M);
        @(negedge CLK_32M);
        v = bus.io_dout;
        if (a == 8'h84)
            check(v === rom_byte(m_addr), "read_data", 32'(v), 32'(rom_byte(m_addr)));
        @(posedge CLK_32M); #1;
        bus.io_req = 1'b0;
        bus.io_rd  = 1'b0;
        @(posedge CLK_32M); #1;
        if (a == 8'h84)
            m_addr = m_addr + 18'd1;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge CLK_32M);
        while ((busy || bus.rom_req) && n < 300) begin
            @(negedge CLK_32M);
            n++;
        end
        check(n < 300, "idle_timeout", 32'(n), 32'(300));
        @(posedge CLK_32M); #1;
    endtask

    task automatic check_idle();
        wait_idle();
        check(bus.io_dout === rom_byte(m_addr), "data_buf", 32'(bus.io_dout), 32'(rom_byte(m_addr)));
        check(bus.rom_addr === m_addr, "last_fetch_addr", 32'(bus.rom_addr), 32'(m_addr));
    endtask

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog expired at %0t", $time);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog");
    end

    logic [7:0] rv;
    logic [7:0] undec[6] = '{8'h83, 8'h84, 8'h85, 8'h87, 8'h00, 8'hC0};
    int         n0;
    int         op;

    initial begin
        reset       = 1'b1;
        bus.io_addr = 8'h00;
        bus.io_din  = 8'h00;
        bus.io_req  = 1'b0;
        bus.io_rd   = 1'b0;
        bus.io_wr   = 1'b0;
        repeat (4) @(posedge CLK_32M);
        @(negedge CLK_32M);
        check(sample_out === 16'h0000, "rst_sample_out", 32'(sample_out), 32'h0);
        check(bus.rom_req === 1'b0, "rst_rom_req", 32'(bus.rom_req), 32'h0);
        check(bus.io_dout === 8'h00, "rst_io_dout", 32'(bus.io_dout), 32'h0);
        check(busy === 1'b0, "rst_busy", 32'(busy), 32'h0);
        check(bus.rom_addr === 18'h0, "rst_rom_addr", 32'(bus.rom_addr), 32'h0);
        @(posedge CLK_32M); #1;
        reset = 1'b0;
        @(posedge CLK_32M); #1;

        // Address latch and fixed-data fetch.
        fixed_5a  = 1'b1;
        fixed_dly = 6;
        io_write(8'h80, 8'h12);
        io_write(8'h81, 8'h03);
        check_idle();
        check(bus.rom_addr === 18'h06240, "addr_latch", 32'(bus.rom_addr), 32'h06240);
        io_read(8'h84, rv);
        check(rv === 8'h5A, "read_5a", 32'(rv), 32'h5A);
        check_idle();
        check(bus.rom_addr === 18'h06241, "addr_incr", 32'(bus.rom_addr), 32'h06241);

        // DAC conversion.
        io_write(8'h82, 8'h00);
        check(sample_out === 16'h8000, "dac_00", 32'(sample_out), 32'h8000);
        io_write(8'h82, 8'hFF);
        check(sample_out === 16'h7F00, "dac_ff", 32'(sample_out), 32'h7F00);
        io_write(8'h82, 8'h80);
        check(sample_out === 16'h0000, "dac_80", 32'(sample_out), 32'h0000);

        // Address wrap at the top of the ROM.
        fixed_5a  = 1'b0;
        fixed_dly = 0;
        io_write(8'h80, 8'hFF);
        io_write(8'h81, 8'hFF);
        check_idle();
        check(bus.rom_addr === 18'h3FFE0, "addr_top", 32'(bus.rom_addr), 32'h3FFE0);
        for (int i = 0; i < 31; i++) begin
            io_read(8'h84, rv);
            wait_idle();
        end
        check(bus.rom_addr === 18'h3FFFF, "addr_last", 32'(bus.rom_addr), 32'h3FFFF);
        io_read(8'h84, rv);
        check_idle();
        check(bus.rom_addr === 18'h00000, "addr_wrap", 32'(bus.rom_addr), 32'h0);

        // Address change while a fetch is outstanding.
        fixed_dly = 8;
        io_write(8'h80, 8'h34);
        n0 = fetch_q.size();
        io_write(8'h81, 8'h01);
        check_idle();
        check(fetch_q.size() - n0 == 1, "restart_refetch", 32'(fetch_q.size() - n0), 32'd1);
        check(bus.rom_addr === 18'h02680, "restart_addr", 32'(bus.rom_addr), 32'h02680);
        check(bus.io_dout === rom_byte(18'h02680), "restart_data", 32'(bus.io_dout),
              32'(rom_byte(18'h02680)));

        // Random traffic.
        fixed_dly = 0;
        for (int i = 0; i < 80; i++) begin
            op = int'($urandom_range(0, 9));
            case (op)
                0, 1: io_write(8'h80, 8'($urandom));
                2, 3: io_write(8'h81, 8'($urandom));
                4:    io_write(8'h82, 8'($urandom));
                5, 6, 7: begin
                    wait_idle();
                    io_read(8'h84, rv);
                end
                8:    io_write(undec[$urandom_range(0, 5)], 8'($urandom));
                default: io_read(($urandom_range(0, 1) != 0) ? 8'h81 : 8'h00, rv);
            endcase
            if ($urandom_range(0, 1) != 0)
                check_idle();
        end
        check_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
